pb_scan_ctrl: RTL and testbench

PB_SCAN_CTRL -- requirements
Module: pb_scan_ctrl

---
 rtl/pb_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pb_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_scan_ctrl.sv
// pb_scan_ctrl: scans NUM_PB push-buttons at roughly 220 Hz and debounces them
// with a 3-sample shift register. Each press raises a sticky request, and the
// requests are handed out one at a time, lowest index first, over a valid/ack
// handshake.
// Optional feature: define PB_AUTOREPEAT_EN to make a held button re-fire after
// RPT_DELAY ticks and then every RPT_RATE ticks.
module pb_scan_ctrl #(
  parameter int CLK_DIV   = 454545,
  parameter int NUM_PB    = 4,
  parameter int RPT_DELAY = 110,
  parameter int RPT_RATE  = 22,
  localparam int ID_W     = (NUM_PB > 1) ? $clog2(NUM_PB) : 1
) (
  input  logic              Clk_100MHz,
  input  logic              reset,
  input  logic [NUM_PB-1:0] pb_in,
  input  logic              cmd_ack,
  output logic              cmd_valid,
  output logic [ID_W-1:0]   cmd_id,
  output logic [NUM_PB-1:0] pb_level,
  output logic              scan_tick,
  output logic              cmd_lost
);

  localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [NUM_PB-1:0] PB_ONE    = NUM_PB'(1);

  typedef enum logic [0:0] {
    IDLE,
    ISSUE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic [NUM_PB-1:0] s1;
  logic [NUM_PB-1:0] s2;
  logic [NUM_PB-1:0] s3;
  logic [NUM_PB-1:0] press_evt;
  logic [NUM_PB-1:0] rpt_evt;
  logic [NUM_PB-1:0] any_evt;
  logic [NUM_PB-1:0] pending;
  logic [NUM_PB-1:0] clr_mask;
  logic [ID_W-1:0]   low_idx;
  logic              load_id;

  // The strobe is decoded from the divider so it lines up exactly with the wrap.
  assign scan_tick = (tick_cnt == TICK_LAST);

  // Free-running scan divider, wrapping after CLK_DIV cycles.
  always_ff @(posedge Clk_100MHz) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (scan_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Sample the raw buttons only on scan ticks; the stages hold in between.
  always_ff @(posedge Clk_100MHz) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (scan_tick) begin
      s1 <= pb_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A press is two consecutive high samples after a low one, seen at the tick.
  assign press_evt = {NUM_PB{scan_tick}} & s1 & s2 & ~s3;
  assign pb_level  = s1 & s2;

`ifdef PB_AUTOREPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_M1 = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_M1  = RPT_W'(RPT_RATE - 1);

  logic [RPT_W-1:0]  rpt_cnt [NUM_PB];
  logic [NUM_PB-1:0] rpt_phase;

  // A repeat fires on the tick that completes the current interval: the long
  // first delay until the first repeat, the short rate afterwards.
  always_comb begin
    rpt_evt = '0;
    for (int i = 0; i < NUM_PB; i++) begin
      rpt_evt[i] = scan_tick && pb_level[i] &&
                   (rpt_cnt[i] == (rpt_phase[i] ? RATE_M1 : DELAY_M1));
    end
  end

  // Per-button held-tick counters; released buttons restart from the long delay.
  always_ff @(posedge Clk_100MHz) begin
    if (reset) begin
      for (int i = 0; i < NUM_PB; i++) begin
        rpt_cnt[i] <= '0;
      end
      rpt_phase <= '0;
    end else begin
      for (int i = 0; i < NUM_PB; i++) begin
        if (!pb_level[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_phase[i] <= 1'b0;
        end else if (scan_tick) begin
          if (rpt_evt[i]) begin
            rpt_cnt[i]   <= '0;
            rpt_phase[i] <= 1'b1;
          end else begin
            rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
          end
        end
      end
    end
  end
`else
  // Auto-repeat is compiled out, so a held button fires once per press. The
  // expression is constant zero for every legal (>= 1) repeat setting.
  assign rpt_evt = {NUM_PB{(RPT_DELAY < 1) && (RPT_RATE < 1)}};
`endif

  assign any_evt = press_evt | rpt_evt;

  // Fixed priority: the lowest pending index is the next one presented.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_PB - 1; i >= 0; i--) begin
      if (pending[i]) begin
        low_idx = ID_W'(i);
      end
    end
  end

  // Sticky requests: a new event beats a same-cycle acknowledge, and an event
  // landing on a request that is still waiting is merged and flagged as lost.
  always_ff @(posedge Clk_100MHz) begin
    if (reset) begin
      pending  <= '0;
      cmd_lost <= 1'b0;
    end else begin
      pending  <= (pending & ~clr_mask) | any_evt;
      cmd_lost <= |(any_evt & pending & ~clr_mask);
    end
  end

  // The presented index is captured when leaving IDLE and frozen during ISSUE.
  always_ff @(posedge Clk_100MHz) begin
    if (reset) begin
      cmd_id <= '0;
    end else if (load_id) begin
      cmd_id <= low_idx;
    end
  end

  // Handshake FSM state register.
  always_ff @(posedge Clk_100MHz) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake FSM: always passing back through IDLE gives a gap between commands.
  always_comb begin
    state_nxt = state;
    cmd_valid = 1'b0;
    load_id   = 1'b0;
    clr_mask  = '0;
    case (state)
      IDLE: begin
        if (|pending) begin
          load_id   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ack) begin
          clr_mask  = PB_ONE << cmd_id;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pb_scan_ctrl.sv
// tb_pb_scan_ctrl: table vectors, hand-written corner sequences and a random
// run for pb_scan_ctrl, all checked against a sample-history reference model.
// Optional feature: PB_AUTOREPEAT_EN adds the held-button repeat sequence.
module tb_pb_scan_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int NUM_PB    = 4;
  localparam int RPT_DELAY = 3;
  localparam int RPT_RATE  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pb_in;
  logic       cmd_ack;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic [3:0] pb_level;
  logic       scan_tick;
  logic       cmd_lost;

  int compared   = 0;
  int mismatched = 0;

  // Clock generator.
  always #5 clk = ~clk;

  pb_scan_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .NUM_PB   (NUM_PB),
    .RPT_DELAY(RPT_DELAY),
    .RPT_RATE (RPT_RATE)
  ) dut (
    .Clk_100MHz(clk),
    .reset     (reset),
    .pb_in     (pb_in),
    .cmd_ack   (cmd_ack),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .pb_level  (pb_level),
    .scan_tick (scan_tick),
    .cmd_lost  (cmd_lost)
  );

  // Reference model: per-button history of the last three tick samples, a
  // set of outstanding requests and the one currently presented.
  bit              hist [NUM_PB][$];
  bit [NUM_PB-1:0] mPend;
  bit              mBusy;
  int              mId;
  bit              mLost;
  int              mCycles;
`ifdef PB_AUTOREPEAT_EN
  int              mHeld [NUM_PB];
`endif

  // Observations gathered from the DUT for the scenario-level checks.
  int         obsValid;
  int         obsFirst;
  int         obsLast;
  int         obsIdChanges;
  int         obsLost;
  logic [3:0] obsLevelOr;

  typedef struct {
    logic [3:0] pb;
    logic       ack;
    logic [3:0] expLevel;
    int         expValid;
    int         expFirst;
    int         expLast;
  } vec_t;

  vec_t vecs [9];

  task automatic modelReset();
    for (int i = 0; i < NUM_PB; i++) begin
      hist[i].delete();
      repeat (3) hist[i].push_back(1'b0);
`ifdef PB_AUTOREPEAT_EN
      mHeld[i] = 0;
`endif
    end
    mPend   = '0;
    mBusy   = 1'b0;
    mId     = 0;
    mLost   = 1'b0;
    mCycles = 0;
  endtask

  task automatic modelStep(input logic [3:0] pb, input logic ack, input logic rst);
    bit [NUM_PB-1:0] evt;
    bit [NUM_PB-1:0] clr;
    bit              lvl;
    evt = '0;
    clr = '0;
    if (rst) begin
      modelReset();
      return;
    end
    if ((mCycles % CLK_DIV) == CLK_DIV - 1) begin
      for (int i = 0; i < NUM_PB; i++) begin
        lvl = hist[i][2] && hist[i][1];
        if (lvl && !hist[i][0]) evt[i] = 1'b1;
`ifdef PB_AUTOREPEAT_EN
        if (lvl) begin
          mHeld[i]++;
          if (mHeld[i] == RPT_DELAY ||
              (mHeld[i] > RPT_DELAY && ((mHeld[i] - RPT_DELAY) % RPT_RATE) == 0))
            evt[i] = 1'b1;
        end else begin
          mHeld[i] = 0;
        end
`endif
        hist[i].push_back(pb[i]);
        void'(hist[i].pop_front());
      end
    end
    if (mBusy && ack) clr[mId] = 1'b1;
    mLost = |(evt & mPend & ~clr);
    if (!mBusy && mPend != 0) begin
      mBusy = 1'b1;
      for (int j = 0; j < NUM_PB; j++) begin
        if (mPend[j]) begin
          mId = j;
          break;
        end
      end
    end else if (mBusy && ack) begin
      mBusy = 1'b0;
    end
    mPend = (mPend & ~clr) | evt;
    mCycles++;
  endtask

  function automatic logic [3:0] modelLevel();
    logic [3:0] l;
    l = '0;
    for (int i = 0; i < NUM_PB; i++) l[i] = hist[i][2] & hist[i][1];
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check("cmd_valid", 32'(cmd_valid), 32'(mBusy));
    if (mBusy) check("cmd_id", 32'(cmd_id), 32'(mId));
    check("pb_level", 32'(pb_level), 32'(modelLevel()));
    check("scan_tick", 32'(scan_tick), 32'((mCycles % CLK_DIV) == CLK_DIV - 1));
    check("cmd_lost", 32'(cmd_lost), 32'(mLost));
  endtask

  task automatic clearObs();
    obsValid     = 0;
    obsFirst     = -1;
    obsLast      = -1;
    obsIdChanges = 0;
    obsLost      = 0;
    obsLevelOr   = '0;
  endtask

  // One clock: drive on the falling edge, step the model on the rising edge,
  // then compare and record on the next falling edge.
  task automatic applyStimulus(input logic [3:0] pb, input logic ack, input logic rst);
    pb_in   = pb;
    cmd_ack = ack;
    reset   = rst;
    @(posedge clk);
    modelStep(pb, ack, rst);
    @(negedge clk);
    checkOutput();
    if (cmd_valid === 1'b1) begin
      if (obsValid > 0 && int'(cmd_id) != obsLast) obsIdChanges++;
      if (obsValid == 0) obsFirst = int'(cmd_id);
      obsLast = int'(cmd_id);
      obsValid++;
    end
    if (cmd_lost === 1'b1) obsLost++;
    obsLevelOr |= pb_level;
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic runTick(input logic [3:0] pb, input logic ack);
    repeat (CLK_DIV) applyStimulus(pb, ack, 1'b0);
  endtask

  initial begin
    logic [3:0] rndPb;
    pb_in   = '0;
    cmd_ack = 1'b0;
    reset   = 1'b1;

    // Each row spans one scan period ending on its tick; expected level is at
    // the end of the row, valid counts/ids are over the row's cycles.
    vecs[0] = '{4'b0010, 1'b1, 4'b0000, 0, -1, -1};
    vecs[1] = '{4'b0010, 1'b1, 4'b0010, 0, -1, -1};
    vecs[2] = '{4'b0010, 1'b1, 4'b0010, 0, -1, -1};
    vecs[3] = '{4'b0000, 1'b1, 4'b0000, 1,  1,  1};
    vecs[4] = '{4'b0101, 1'b1, 4'b0000, 0, -1, -1};
    vecs[5] = '{4'b0101, 1'b1, 4'b0101, 0, -1, -1};
    vecs[6] = '{4'b0000, 1'b1, 4'b0000, 0, -1, -1};
    vecs[7] = '{4'b0000, 1'b1, 4'b0000, 2,  0,  2};
    vecs[8] = '{4'b0000, 1'b1, 4'b0000, 0, -1, -1};

    $display("[TB] reset and table vectors");
    doReset();
    for (int r = 0; r < 9; r++) begin
      clearObs();
      runTick(vecs[r].pb, vecs[r].ack);
      check($sformatf("vec%0d_level", r), 32'(pb_level), 32'(vecs[r].expLevel));
      check($sformatf("vec%0d_valid", r), 32'(obsValid), 32'(vecs[r].expValid));
      if (vecs[r].expValid > 0) begin
        check($sformatf("vec%0d_first", r), 32'(obsFirst), 32'(vecs[r].expFirst));
        check($sformatf("vec%0d_last", r), 32'(obsLast), 32'(vecs[r].expLast));
      end
    end

    $display("[TB] held request with repeated press");
    doReset();
    clearObs();
    for (int r = 0; r < 10; r++) begin
      runTick((r < 3 || (r >= 5 && r < 8)) ? 4'b1000 : 4'b0000, 1'b0);
    end
    check("merge_lost_count", 32'(obsLost), 32'd1);
    check("merge_valid_cycles", 32'(obsValid), 32'd28);
    check("merge_id", 32'(obsFirst), 32'd3);
    check("merge_id_stable", 32'(obsIdChanges), 32'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    check("merge_valid_after_ack", 32'(cmd_valid), 32'd0);
    clearObs();
    runTick(4'b0000, 1'b1);
    runTick(4'b0000, 1'b1);
    check("merge_no_reissue", 32'(obsValid), 32'd0);

    $display("[TB] reset during an issued command");
    doReset();
    for (int r = 0; r < 3; r++) runTick(4'b0010, 1'b0);
    runTick(4'b0000, 1'b0);
    check("pre_reset_valid", 32'(cmd_valid), 32'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    check("reset_drops_valid", 32'(cmd_valid), 32'd0);
    clearObs();
    for (int r = 0; r < 6; r++) runTick(4'b0000, 1'b1);
    check("no_cmd_after_reset", 32'(obsValid), 32'd0);

    $display("[TB] glitch between ticks");
    doReset();
    clearObs();
    applyStimulus(4'b0100, 1'b1, 1'b0);
    repeat (15) applyStimulus(4'b0000, 1'b1, 1'b0);
    check("glitch_no_cmd", 32'(obsValid), 32'd0);
    check("glitch_level", 32'(obsLevelOr), 32'd0);

`ifdef PB_AUTOREPEAT_EN
    $display("[TB] auto-repeat on a held button");
    doReset();
    clearObs();
    for (int r = 0; r < 10; r++) runTick(4'b0001, 1'b1);
    for (int r = 0; r < 4; r++) runTick(4'b0000, 1'b1);
    check("repeat_cmd_count", 32'(obsValid), 32'd5);
    check("repeat_lost", 32'(obsLost), 32'd0);
`endif

    $display("[TB] randomized buttons and acknowledges");
    doReset();
    rndPb = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_PB; i++) begin
        if ($urandom_range(0, 39) == 0) rndPb[i] = ~rndPb[i];
      end
      applyStimulus(rndPb, 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 699) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
